// File: rtl/adder_pipe_n.sv
// Pipelined N-bit add/subtract: the carry chain is cut into STAGES equal chunks, one per register.
// Define ADDER_PIPE_OVF_EN to add a registered signed-overflow output OVF.
module adder_pipe_n #(
   parameter int N      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] P,
   input  logic [N-1:0] Q,
   input  logic         Cin,
   input  logic         op_sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] SUM,
   output logic         Cout
`ifdef ADDER_PIPE_OVF_EN
   ,
   output logic         OVF
`endif
);

   localparam int M = N / STAGES;
   localparam int L = STAGES - 1;

   if (STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_cfg
      $error("adder_pipe_n: STAGES must lie in 1..N and divide N");
   end

   logic [STAGES-1:0] valid_r;
   logic [STAGES-1:0] adv;
   logic [STAGES-1:0] load;
   logic              accept;

   // Operand registers hold only the not-yet-added upper bits, shifted down to bit 0.
   logic [N-1:0] p_r [STAGES];
   logic [N-1:0] q_r [STAGES];
   logic [N-1:0] s_r [STAGES];
   logic [STAGES-1:0] c_r;

   logic [N-1:0] src_p [STAGES];
   logic [N-1:0] src_q [STAGES];
   logic [N-1:0] src_s [STAGES];
   logic [STAGES-1:0] src_c;

   logic [M:0]   chunk [STAGES];
   logic [N-1:0] nxt_p [STAGES];
   logic [N-1:0] nxt_q [STAGES];
   logic [N-1:0] nxt_s [STAGES];
   logic [STAGES-1:0] nxt_c;

   for (genvar k = 0; k < STAGES; k++) begin : g_src
      if (k == 0) begin : g_head
         assign src_p[0] = P;
         assign src_q[0] = op_sub ? ~Q : Q;
         assign src_s[0] = '0;
         assign src_c[0] = op_sub | Cin;
      end else begin : g_body
         assign src_p[k] = p_r[k-1];
         assign src_q[k] = q_r[k-1];
         assign src_s[k] = s_r[k-1];
         assign src_c[k] = c_r[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         chunk[k] = {1'b0, src_p[k][M-1:0]} + {1'b0, src_q[k][M-1:0]} + (M+1)'(src_c[k]);
         nxt_s[k] = src_s[k] | (N'(chunk[k][M-1:0]) << (k * M));
         nxt_c[k] = chunk[k][M];
         nxt_p[k] = src_p[k] >> M;
         nxt_q[k] = src_q[k] >> M;
      end
   end

   // Walk from the output back: a stage may move when the stage after it is empty or moving.
   always_comb begin
      logic room;
      room = out_ready;
      adv  = '0;
      for (int k = L; k >= 0; k--) begin
         adv[k] = valid_r[k] && room;
         room   = !valid_r[k] || adv[k];
      end
   end

   assign in_ready = !reset && (!valid_r[0] || adv[0]);
   assign accept   = in_valid && in_ready;
   assign load     = STAGES'({adv, accept});

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= '0;
         c_r     <= '0;
         for (int k = 0; k < STAGES; k++) begin
            p_r[k] <= '0;
            q_r[k] <= '0;
            s_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               valid_r[k] <= 1'b1;
               p_r[k]     <= nxt_p[k];
               q_r[k]     <= nxt_q[k];
               s_r[k]     <= nxt_s[k];
               c_r[k]     <= nxt_c[k];
            end else if (adv[k]) begin
               valid_r[k] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = valid_r[L];
   assign SUM       = s_r[L];
   assign Cout      = c_r[L];

`ifdef ADDER_PIPE_OVF_EN
   logic nxt_ovf;
   logic ovf_r;

   // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
   assign nxt_ovf = src_p[L][M-1] ^ src_q[L][M-1] ^ chunk[L][M-1] ^ chunk[L][M];

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_r <= 1'b0;
      end else if (load[L]) begin
         ovf_r <= nxt_ovf;
      end
   end

   assign OVF = ovf_r;
`endif

endmodule
